// File: rtl/dsram_pkg.sv
// Shared encodings for the data-side SRAM responder.
// Access sizes and responder FSM states.
package dsram_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/dsram_lane_mask.sv
// Byte-lane write mask from access size and low address bits.
// Misaligned or reserved-size accesses yield an empty mask.
module dsram_lane_mask
  import dsram_pkg::*;
(
  input  logic [1:0] size,
  input  logic [1:0] addr_lo,
  output logic [3:0] mask
);

  always_comb begin
    mask = 4'b0000;
    case (size)
      SZ_BYTE: mask = 4'b0001 << addr_lo;
      SZ_HALF: begin
        if (!addr_lo[0])
          mask = addr_lo[1] ? 4'b1100 : 4'b0011;
      end
      SZ_WORD: begin
        if (addr_lo == 2'b00)
          mask = 4'b1111;
      end
      default: mask = 4'b0000;
    endcase
  end

endmodule

// File: rtl/dsram_responder.sv
// Data-side SRAM-like responder: one request at a time,
// data_ok a fixed LATENCY cycles after the addr_ok handshake.
module dsram_responder
  import dsram_pkg::*;
#(
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  state_e                  state;
  logic [3:0]              cnt;
  logic [31:0]             rdata_q;
  logic [31:0]             mem [DEPTH];
  logic [DEPTH_LOG2-1:0]   idx;
  logic [3:0]              wmask;
  logic                    hs;
  logic                    unused_addr_hi;

  // Upper address bits are dropped so accesses wrap over the array.
  assign idx            = data_addr[DEPTH_LOG2+1:2];
  assign unused_addr_hi = ^data_addr[31:DEPTH_LOG2+2];

  assign data_addr_ok = (state == IDLE);
  assign data_data_ok = (state == RESP);
  assign data_rdata   = rdata_q;
  assign hs           = data_req & data_addr_ok;

  dsram_lane_mask u_lane_mask (
    .size    (data_size),
    .addr_lo (data_addr[1:0]),
    .mask    (wmask)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      rdata_q <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (data_req) begin
            if (!data_wr)
              rdata_q <= mem[idx];
            if (LATENCY == 1) begin
              state <= RESP;
            end else begin
              state <= WAIT;
              cnt   <= CNT_INIT;
            end
          end
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1)
            state <= RESP;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Array is never reset; writes commit on the handshake edge.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (hs && data_wr && wmask[i])
        mem[idx][8*i +: 8] <= data_wdata[8*i +: 8];
    end
  end

endmodule

// File: tb/tb_dsram_responder.sv
// Bench for dsram_responder: three instances with different
// depth/latency, checked against a byte-level memory model.
module tb_dsram_responder;
  import dsram_pkg::*;

  localparam int NI = 3;

  function automatic int dl_of(input int k);
    case (k)
      0:       return 4;
      1:       return 10;
      default: return 6;
    endcase
  endfunction

  function automatic int lat_of(input int k);
    case (k)
      0:       return 3;
      1:       return 1;
      default: return 4;
    endcase
  endfunction

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req   [NI];
  logic        wr    [NI];
  logic [1:0]  size  [NI];
  logic [31:0] addr  [NI];
  logic [31:0] wdata [NI];
  logic        addr_ok [NI];
  logic        data_ok [NI];
  logic [31:0] rdata   [NI];

  logic [1:0]  lm_size;
  logic [1:0]  lm_lo;
  logic [3:0]  lm_mask;

  int checks   = 0;
  int failures = 0;

  logic [31:0] mdata   [NI][1024];
  logic [3:0]  mknown  [NI][1024];
  logic [31:0] last_val [NI];
  logic [31:0] last_km  [NI];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    dsram_responder #(
      .DEPTH_LOG2 (dl_of(g)),
      .LATENCY    (lat_of(g))
    ) u_dut (
      .clk          (clk),
      .rst          (rst),
      .data_req     (req[g]),
      .data_wr      (wr[g]),
      .data_size    (size[g]),
      .data_addr    (addr[g]),
      .data_wdata   (wdata[g]),
      .data_addr_ok (addr_ok[g]),
      .data_data_ok (data_ok[g]),
      .data_rdata   (rdata[g])
    );
  end

  dsram_lane_mask u_lm (
    .size    (lm_size),
    .addr_lo (lm_lo),
    .mask    (lm_mask)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  // Reference: an access of 2^size bytes must be naturally aligned.
  function automatic logic [3:0] exp_mask(input int sz, input int lo);
    int n;
    if (sz > 2) return 4'b0000;
    n = 1 << sz;
    if ((lo % n) != 0) return 4'b0000;
    return 4'(((1 << n) - 1) << lo);
  endfunction

  function automatic int widx(input int k, input logic [31:0] a);
    return int'((a >> 2) & ((32'd1 << dl_of(k)) - 32'd1));
  endfunction

  function automatic logic [31:0] expand(input logic [3:0] m);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 4; i++)
      if (m[i]) r[8*i +: 8] = 8'hFF;
    return r;
  endfunction

  task automatic reset_model_rdata();
    for (int k = 0; k < NI; k++) begin
      last_val[k] = 32'd0;
      last_km[k]  = 32'hFFFF_FFFF;
    end
  endtask

  task automatic txn(input int k, input bit w, input logic [1:0] sz,
                     input logic [31:0] a, input logic [31:0] wd,
                     output logic [31:0] got);
    int lat;
    int wi;
    logic [3:0]  m;
    logic [31:0] exp;
    logic [31:0] km;
    lat = lat_of(k);
    got = '0;
    @(negedge clk);
    check("pre_addr_ok", 32'(addr_ok[k]), 32'd1);
    req[k] = 1'b1; wr[k] = w; size[k] = sz;
    addr[k] = a; wdata[k] = wd;
    wi = widx(k, a);
    m  = exp_mask(int'(sz), int'(a[1:0]));
    if (w) begin
      for (int i = 0; i < 4; i++) begin
        if (m[i]) begin
          mdata[k][wi][8*i +: 8] = wd[8*i +: 8];
          mknown[k][wi][i] = 1'b1;
        end
      end
      exp = last_val[k];
      km  = last_km[k];
    end else begin
      exp = mdata[k][wi];
      km  = expand(mknown[k][wi]);
      last_val[k] = exp;
      last_km[k]  = km;
    end
    for (int j = 1; j <= lat; j++) begin
      @(negedge clk);
      if (j == lat) begin
        req[k] = 1'b0;
      end else begin
        // Requests while busy must be ignored entirely.
        req[k]   = 1'($urandom_range(0, 1));
        wr[k]    = 1'b1;
        size[k]  = SZ_WORD;
        addr[k]  = $urandom & 32'hFFFF_FFFC;
        wdata[k] = $urandom;
      end
      check("busy_addr_ok", 32'(addr_ok[k]), 32'd0);
      check("data_ok", 32'(data_ok[k]), 32'(j == lat));
      if (j == lat) begin
        got = rdata[k];
        check(w ? "wr_rdata_hold" : "rdata", rdata[k] & km, exp & km);
      end
    end
  endtask

  logic [31:0] obs;

  initial begin
    for (int k = 0; k < NI; k++) begin
      req[k] = 1'b0; wr[k] = 1'b0; size[k] = '0;
      addr[k] = '0; wdata[k] = '0;
      for (int i = 0; i < 1024; i++) begin
        mknown[k][i] = 4'b0000;
        mdata[k][i]  = '0;
      end
    end
    lm_size = '0;
    lm_lo   = '0;
    reset_model_rdata();

    #1 rst = 1'b1;
    #1;
    for (int k = 0; k < NI; k++)
      check("rst_addr_ok_async", 32'(addr_ok[k]), 32'd1);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      check("idle_addr_ok", 32'(addr_ok[k]), 32'd1);
      check("idle_data_ok", 32'(data_ok[k]), 32'd0);
      check("idle_rdata", rdata[k], 32'd0);
    end

    for (int s = 0; s < 4; s++) begin
      for (int lo = 0; lo < 4; lo++) begin
        lm_size = 2'(s);
        lm_lo   = 2'(lo);
        #1;
        check("lane_mask", 32'(lm_mask), 32'(exp_mask(s, lo)));
      end
    end

    txn(0, 1'b1, SZ_WORD, 32'h100, 32'hDEAD_BEEF, obs);
    txn(0, 1'b0, SZ_WORD, 32'h100, 32'h0, obs);
    check("word_rd", obs, 32'hDEAD_BEEF);

    txn(0, 1'b1, SZ_WORD, 32'h40, 32'h0, obs);
    txn(0, 1'b1, SZ_BYTE, 32'h42, 32'hABAB_ABAB, obs);
    txn(0, 1'b0, SZ_BYTE, 32'h40, 32'h0, obs);
    check("byte_lane", obs, 32'h00AB_0000);
    txn(0, 1'b1, SZ_HALF, 32'h40, 32'hCDCD_CDCD, obs);
    txn(0, 1'b0, SZ_WORD, 32'h40, 32'h0, obs);
    check("half_lane", obs, 32'h00AB_CDCD);

    txn(0, 1'b1, SZ_WORD, 32'h41, 32'h1234_5678, obs);
    txn(0, 1'b1, SZ_HALF, 32'h43, 32'h1234_5678, obs);
    txn(0, 1'b1, 2'd3,    32'h40, 32'h1234_5678, obs);
    txn(0, 1'b0, SZ_WORD, 32'h40, 32'h0, obs);
    check("misaligned_noop", obs, 32'h00AB_CDCD);

    txn(0, 1'b1, SZ_WORD, 32'h000, 32'h1111_1111, obs);
    txn(0, 1'b0, SZ_WORD, 32'h040, 32'h0, obs);
    check("wrap", obs, 32'h1111_1111);

    // Write handshake, then reset while the response is pending.
    @(negedge clk);
    req[2] = 1'b1; wr[2] = 1'b1; size[2] = SZ_WORD;
    addr[2] = 32'h20; wdata[2] = 32'hCAFE_F00D;
    mdata[2][widx(2, 32'h20)]  = 32'hCAFE_F00D;
    mknown[2][widx(2, 32'h20)] = 4'hF;
    @(negedge clk);
    req[2] = 1'b0;
    check("rstw_addr_ok_busy", 32'(addr_ok[2]), 32'd0);
    check("rstw_data_ok_busy", 32'(data_ok[2]), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rstw_addr_ok", 32'(addr_ok[2]), 32'd1);
    check("rstw_data_ok", 32'(data_ok[2]), 32'd0);
    check("rstw_rdata", rdata[2], 32'd0);
    reset_model_rdata();
    @(negedge clk);
    rst = 1'b0;
    for (int j = 3; j <= 6; j++) begin
      if (j > 3) @(negedge clk);
      check("rstw_no_data_ok", 32'(data_ok[2]), 32'd0);
    end
    txn(2, 1'b0, SZ_WORD, 32'h20, 32'h0, obs);
    check("rstw_committed", obs, 32'hCAFE_F00D);

    for (int k = 0; k < NI; k++) begin
      for (int n = 0; n < 80; n++) begin
        logic [31:0] a;
        logic [1:0]  lo;
        lo = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'($urandom_range(0, 3));
        a  = ($urandom << (dl_of(k) + 2))
           | (32'($urandom_range(0, 7)) << 2) | 32'(lo);
        txn(k, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
            a, $urandom, obs);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
